cardinal_nic_sched: RTL and testbench

Processor-side sequencer for `cardinal_nic`, sitting between a core's packet ports and the NIC's 2-bit-addressed register port. It accepts outbound packets on a valid/ready port and polls the NIC output status before writing each one to the output channel buffer. It also polls the NIC input status and drains received packets to a valid/ready port. The send and receive jobs share the single NIC register port under round-robin with back-off after failed polls.

---
 rtl/cardinal_pkg.sv | 25 ++
 rtl/cardinal_nic_sched.sv | 163 ++++++++++++++++
 tb/tb_cardinal_nic_sched.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cardinal_pkg.sv
// Shared definitions for the cardinal NIC register port and the processor-side scheduler.
package cardinal_pkg;

    localparam logic [1:0] NIC_ADDR_IN_BUF   = 2'b00;
    localparam logic [1:0] NIC_ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] NIC_ADDR_OUT_BUF  = 2'b10;
    localparam logic [1:0] NIC_ADDR_OUT_STAT = 2'b11;

    localparam int unsigned NIC_STAT_BIT = 63;

    typedef enum logic [2:0] {
        StIdle,
        StTxPoll,
        StTxWrite,
        StRxPoll,
        StRxRead,
        StWait
    } sched_state_e;

    typedef enum logic {
        OpTx,
        OpRx
    } sched_op_e;

endpackage

// File: rtl/cardinal_nic_sched.sv
// Round-robin send/receive sequencer in front of the cardinal NIC register port.
// Optional per-direction packet counters are enabled by defining NIC_SCHED_STATS_EN.
module cardinal_nic_sched
    import cardinal_pkg::*;
#(
    parameter int unsigned POLL_GAP = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [0:63] tx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic [0:63] rx_data,
    output logic [0:1]  nic_addr,
    output logic [0:63] nic_d_in,
    input  logic [0:63] nic_d_out,
    output logic        nic_en,
    output logic        nic_wr_en
`ifdef NIC_SCHED_STATS_EN
    ,
    output logic [0:15] tx_count,
    output logic [0:15] rx_count
`endif
);

    // Keep the counter at least one bit wide so POLL_GAP=0 still elaborates.
    localparam int unsigned CntW = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
    localparam logic [CntW-1:0] GapInit = CntW'(POLL_GAP);
    localparam logic [CntW-1:0] GapOne  = CntW'(1);
    localparam sched_state_e FailNext = (POLL_GAP == 0) ? StIdle : StWait;

    sched_state_e    state_q;
    sched_op_e       last_op_q;
    logic [0:63]     tx_buf_q;
    logic            tx_full_q;
    logic [0:63]     rx_buf_q;
    logic            rx_full_q;
    logic [CntW-1:0] gap_q;
    logic            tx_elig;
    logic            rx_elig;

`ifdef NIC_SCHED_STATS_EN
    logic [0:15] tx_count_q;
    logic [0:15] rx_count_q;

    assign tx_count = tx_count_q;
    assign rx_count = rx_count_q;
`endif

    assign tx_elig  = tx_full_q;
    assign rx_elig  = ~rx_full_q;
    assign tx_ready = ~tx_full_q;
    assign rx_valid = rx_full_q;
    assign rx_data  = rx_buf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            last_op_q  <= OpRx;
            tx_buf_q   <= '0;
            tx_full_q  <= 1'b0;
            rx_buf_q   <= '0;
            rx_full_q  <= 1'b0;
            gap_q      <= '0;
`ifdef NIC_SCHED_STATS_EN
            tx_count_q <= '0;
            rx_count_q <= '0;
`endif
        end else begin
            // Core-side handshakes; set and clear of each flag are mutually exclusive.
            if (tx_valid && !tx_full_q) begin
                tx_buf_q  <= tx_data;
                tx_full_q <= 1'b1;
            end
            if (rx_ready && rx_full_q) begin
                rx_full_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (tx_elig && (!rx_elig || last_op_q == OpRx)) begin
                        state_q   <= StTxPoll;
                        last_op_q <= OpTx;
                    end else if (rx_elig) begin
                        state_q   <= StRxPoll;
                        last_op_q <= OpRx;
                    end
                end
                StTxPoll: begin
                    if (!nic_d_out[NIC_STAT_BIT]) begin
                        state_q <= StTxWrite;
                    end else begin
                        state_q <= FailNext;
                        gap_q   <= GapInit;
                    end
                end
                StTxWrite: begin
                    tx_full_q <= 1'b0;
                    state_q   <= StIdle;
`ifdef NIC_SCHED_STATS_EN
                    tx_count_q <= tx_count_q + 16'd1;
`endif
                end
                StRxPoll: begin
                    if (nic_d_out[NIC_STAT_BIT]) begin
                        state_q <= StRxRead;
                    end else begin
                        state_q <= FailNext;
                        gap_q   <= GapInit;
                    end
                end
                StRxRead: begin
                    rx_buf_q  <= nic_d_out;
                    rx_full_q <= 1'b1;
                    state_q   <= StIdle;
`ifdef NIC_SCHED_STATS_EN
                    rx_count_q <= rx_count_q + 16'd1;
`endif
                end
                StWait: begin
                    if (gap_q <= GapOne) begin
                        state_q <= StIdle;
                    end else begin
                        gap_q <= gap_q - GapOne;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // NIC strobes decode straight from the state register so reset drops them at once.
    always_comb begin
        nic_en    = 1'b0;
        nic_wr_en = 1'b0;
        nic_addr  = NIC_ADDR_IN_BUF;
        nic_d_in  = '0;
        unique case (state_q)
            StTxPoll: begin
                nic_en   = 1'b1;
                nic_addr = NIC_ADDR_OUT_STAT;
            end
            StTxWrite: begin
                nic_en    = 1'b1;
                nic_wr_en = 1'b1;
                nic_addr  = NIC_ADDR_OUT_BUF;
                nic_d_in  = tx_buf_q;
            end
            StRxPoll: begin
                nic_en   = 1'b1;
                nic_addr = NIC_ADDR_IN_STAT;
            end
            StRxRead: begin
                nic_en   = 1'b1;
                nic_addr = NIC_ADDR_IN_BUF;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cardinal_nic_sched.sv
// Scoreboard bench for cardinal_nic_sched with a behavioural NIC register model.
// Stats-counter checks are compiled in when NIC_SCHED_STATS_EN is defined.
module tb_cardinal_nic_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_valid;
    logic        tx_ready;
    logic [0:63] tx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [0:63] rx_data;
    logic [0:1]  nic_addr;
    logic [0:63] nic_d_in;
    logic [0:63] nic_d_out;
    logic        nic_en;
    logic        nic_wr_en;
`ifdef NIC_SCHED_STATS_EN
    logic [0:15] tx_count;
    logic [0:15] rx_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] exp_wr[$];
    logic [63:0] exp_rx[$];
    int          slot_log[$];  // 1 = TX poll, 2 = RX poll

    // NIC model: packet store for the input side, busy window for the output side.
    logic [63:0] pkts[16];
    logic [3:0]  wr_idx = '0;
    logic [3:0]  rd_idx = '0;
    int          out_polls = 0;
    int          in_polls = 0;
    int          busy_until = 0;
    int          nwrites = 0;
    logic        in_avail;
    logic        busy;

    cardinal_nic_sched #(.POLL_GAP(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rx_data   (rx_data),
        .nic_addr  (nic_addr),
        .nic_d_in  (nic_d_in),
        .nic_d_out (nic_d_out),
        .nic_en    (nic_en),
        .nic_wr_en (nic_wr_en)
`ifdef NIC_SCHED_STATS_EN
        ,
        .tx_count  (tx_count),
        .rx_count  (rx_count)
`endif
    );

    always #5 clk = ~clk;

    assign in_avail = (rd_idx != wr_idx);
    assign busy     = (out_polls < busy_until);

    always_comb begin
        nic_d_out = '0;
        if (nic_en) begin
            case (nic_addr)
                2'b00:   nic_d_out = pkts[rd_idx];
                2'b01:   nic_d_out = {63'd0, in_avail};
                2'b11:   nic_d_out = {63'd0, busy};
                default: nic_d_out = '0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (nic_en && !nic_wr_en) begin
            if (nic_addr == 2'b11) out_polls <= out_polls + 1;
            if (nic_addr == 2'b01) in_polls <= in_polls + 1;
            if (nic_addr == 2'b00 && in_avail) rd_idx <= rd_idx + 4'd1;
        end
    end

    // Stimulus side: an accepted outbound packet must later appear as one NIC write.
    always @(posedge clk) begin
        if (!reset && tx_valid && tx_ready) exp_wr.push_back(tx_data);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [63:0] v);
        pkts[wr_idx] = v;
        wr_idx = wr_idx + 4'd1;
        exp_rx.push_back(v);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write or a received packet.
    always @(negedge clk) begin
        if (!reset) begin
            if (nic_en && nic_wr_en) begin
                nwrites <= nwrites + 1;
                if (exp_wr.size() == 0) begin
                    check("unexpected nic write", nic_d_in, 64'd0);
                end else begin
                    check("nic write data", nic_d_in, exp_wr.pop_front());
                    check("nic write addr", 64'(nic_addr), 64'd2);
                end
            end else if (nic_en && nic_addr == 2'b11) begin
                slot_log.push_back(1);
            end else if (nic_en && nic_addr == 2'b01) begin
                slot_log.push_back(2);
            end
            if (rx_valid && rx_ready) begin
                if (exp_rx.size() == 0) check("unexpected rx packet", rx_data, 64'd0);
                else check("rx packet data", rx_data, exp_rx.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int p;
        int ens;
        int w;
        int first_t;
        int last_t;
        int ts;
        bit ok;

        for (int i = 0; i < 16; i++) pkts[i] = '0;
        reset = 1'b1;
        tx_valid = 1'b0;
        tx_data = '0;
        rx_ready = 1'b0;
        repeat (2) tick();

        check("reset nic_en", 64'(nic_en), 64'd0);
        check("reset nic_wr_en", 64'(nic_wr_en), 64'd0);
        check("reset nic_addr", 64'(nic_addr), 64'd0);
        check("reset nic_d_in", nic_d_in, 64'd0);
        check("reset rx_valid", 64'(rx_valid), 64'd0);
        check("reset rx_data", rx_data, 64'd0);
        check("reset tx_ready", 64'(tx_ready), 64'd1);

        // Receive: poll, read, then held until consumed.
        reset = 1'b0;
        offer(64'h0000_0000_0000_0ABC);
        n = 0;
        while (!rx_valid && n < 20) begin
            tick();
            n++;
        end
        check("rx latency edges", 64'(n), 64'd3);
        check("rx_data held", rx_data, 64'h0000_0000_0000_0ABC);
        p = in_polls;
        repeat (10) tick();
        check("no rx poll while full", 64'(in_polls - p), 64'd0);
        check("rx_valid still held", 64'(rx_valid), 64'd1);

        // Send with output buffer free; RX is blocked so timing is exact.
        tx_data = 64'h8A0C_0000_0000_0001;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("tx_ready low after accept", 64'(tx_ready), 64'd0);
        check("idle nic_en", 64'(nic_en), 64'd0);
        tick();
        check("tx poll en", 64'(nic_en), 64'd1);
        check("tx poll wr", 64'(nic_wr_en), 64'd0);
        check("tx poll addr", 64'(nic_addr), 64'd3);
        tick();
        check("tx write en", 64'(nic_en & nic_wr_en), 64'd1);
        check("tx write addr", 64'(nic_addr), 64'd2);
        check("tx write data", nic_d_in, 64'h8A0C_0000_0000_0001);
        tick();
        check("tx_ready restored", 64'(tx_ready), 64'd1);
        check("nic idle after write", 64'(nic_en), 64'd0);

        // Output busy for three polls: each failure costs poll + 2 gap cycles + arbitration.
        busy_until = out_polls + 3;
        p = out_polls;
        tx_data = 64'h1111_2222_3333_4444;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        n = 0;
        ens = 0;
        while (!tx_ready && n < 60) begin
            tick();
            n++;
            if (nic_en) ens++;
        end
        check("busy tx total cycles", 64'(n), 64'd15);
        check("busy out-status polls", 64'(out_polls - p), 64'd4);
        check("busy nic_en cycles", 64'(ens), 64'd5);

        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("rx_valid after consume", 64'(rx_valid), 64'd0);

        // Contention: four sends against four receivable packets.
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) offer(64'h0000_0000_0000_1000 + 64'(i));
        slot_log.delete();
        for (int i = 0; i < 4; i++) begin
            tx_data = 64'hC0DE_0000_0000_0000 | 64'(i);
            tx_valid = 1'b1;
            n = 0;
            while (!tx_ready && n < 40) begin
                tick();
                n++;
            end
            check("contention accept in time", 64'(n < 40), 64'd1);
            tick();
            tx_valid = 1'b0;
        end
        repeat (40) tick();
        ts = 0;
        first_t = -1;
        last_t = -1;
        foreach (slot_log[k]) begin
            if (slot_log[k] == 1) begin
                ts++;
                if (first_t < 0) first_t = k;
                last_t = k;
            end
        end
        ok = (first_t >= 0);
        for (int k = first_t; k >= 0 && k <= last_t; k++) begin
            if (slot_log[k] != (((k - first_t) % 2 == 0) ? 1 : 2)) ok = 1'b0;
        end
        check("contention tx polls", 64'(ts), 64'd4);
        check("contention slots alternate", 64'(ok), 64'd1);
        check("contention writes drained", 64'(exp_wr.size()), 64'd0);
        check("contention rx drained", 64'(exp_rx.size()), 64'd0);
`ifdef NIC_SCHED_STATS_EN
        check("stats tx_count", 64'(tx_count), 64'd6);
        check("stats rx_count", 64'(rx_count), 64'd5);
`endif

        // Reset while TX_WRITE is on the port: strobe drops at once, packet is lost.
        tx_data = 64'hDEAD_BEEF_0000_0007;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < 40) begin
            tick();
            n++;
        end
        tick();
        tx_valid = 1'b0;
        n = 0;
        while (!(nic_en && nic_wr_en) && n < 40) begin
            tick();
            n++;
        end
        check("reached tx write", 64'(nic_en & nic_wr_en), 64'd1);
        w = nwrites;
        reset = 1'b1;
        exp_wr.delete();
        #1;
        check("mid-write reset nic_en", 64'(nic_en), 64'd0);
        check("mid-write reset nic_wr_en", 64'(nic_wr_en), 64'd0);
        check("mid-write reset tx_ready", 64'(tx_ready), 64'd1);
`ifdef NIC_SCHED_STATS_EN
        check("stats tx_count reset", 64'(tx_count), 64'd0);
        check("stats rx_count reset", 64'(rx_count), 64'd0);
`endif
        tick();
        tick();
        reset = 1'b0;
        repeat (20) tick();
        check("no write after reset", 64'(nwrites - w), 64'd0);
        check("final write queue empty", 64'(exp_wr.size()), 64'd0);
        check("final rx queue empty", 64'(exp_rx.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
